// File: rtl/rgb_frame_reader_pkg.sv
// Shared definitions for the RGB frame reader: FSM states, default frame geometry
// and the pixel record carried through the FIFO.
`default_nettype none

package rgb_frame_reader_pkg;

  localparam logic [17:0] RGB_BASE_DEFAULT   = 18'd146944;
  localparam int          NUM_PIXELS_DEFAULT = 76800;
  localparam int          FIFO_DEPTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_ISSUE1 = 3'd2,
    S_ISSUE2 = 3'd3,
    S_STALL  = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // Which word of a pixel pair a returning SRAM read belongs to.
  typedef enum logic [1:0] {
    PH_W0 = 2'd0,
    PH_W1 = 2'd1,
    PH_W2 = 2'd2
  } phase_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

`default_nettype wire

// File: rtl/rgb_frame_reader_pixel_fifo.sv
// Pixel FIFO with occupancy count; head data reads as zero while empty so the
// pixel outputs sit at zero after reset without clearing the storage array.
`default_nettype none

module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb_frame_reader.sv
// Streams one frame of packed RGB pixel pairs (three 16-bit words per pair) out of
// SRAM into a pixel FIFO, issuing reads only when the FIFO can absorb the pair.
`default_nettype none

module rgb_frame_reader
  import rgb_frame_reader_pkg::*;
#(
  parameter logic [17:0] RGB_BASE   = RGB_BASE_DEFAULT,
  parameter int          NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic        Busy,
  output logic        Frame_done
);

  localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0] LAST_WORD    = 17'(NUM_PIXELS * 3 / 2 - 1);
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH - 2);

  state_e        state_q;
  logic [17:0]   addr_q;
  logic [16:0]   word_cnt_q;
  logic [CW-1:0] in_flight_q;
  logic [CW-1:0] in_flight_d;
  logic          busy_q;
  logic          done_q;

  logic          s1_valid_q, s2_valid_q;
  phase_e        s1_phase_q, s2_phase_q;
  logic [7:0]    r0_q, g0_q, r1_q;

  logic          issue_valid;
  phase_e        issue_phase;
  logic          pair_start;
  logic          last_word;
  logic          credit_ok;
  logic [CW:0]   credit_sum;

  logic          fifo_push;
  pixel_t        fifo_wdata;
  pixel_t        fifo_rdata;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign last_word  = (word_cnt_q == LAST_WORD);
  // Pixels already promised to the FIFO count against its space before a new pair starts.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, in_flight_q};
  assign credit_ok  = (credit_sum <= CREDIT_LIMIT);

  always_comb begin
    issue_valid = 1'b0;
    issue_phase = PH_W0;
    pair_start  = 1'b0;
    case (state_q)
      S_IDLE:   pair_start = Enable;
      S_ISSUE0: begin issue_valid = 1'b1; issue_phase = PH_W0; end
      S_ISSUE1: begin issue_valid = 1'b1; issue_phase = PH_W1; end
      S_ISSUE2: begin
        issue_valid = 1'b1;
        issue_phase = PH_W2;
        pair_start  = !last_word && credit_ok;
      end
      S_STALL:  pair_start = credit_ok;
      default:  ;
    endcase
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (pair_start) in_flight_d = in_flight_d + CW'(2);
    if (fifo_push)  in_flight_d = in_flight_d - CW'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      in_flight_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      in_flight_q <= in_flight_d;
      case (state_q)
        S_IDLE: if (Enable) begin
          state_q    <= S_ISSUE0;
          addr_q     <= RGB_BASE;
          word_cnt_q <= '0;
          busy_q     <= 1'b1;
        end
        S_ISSUE0: begin
          state_q    <= S_ISSUE1;
          addr_q     <= addr_q + 18'd1;
          word_cnt_q <= word_cnt_q + 17'd1;
        end
        S_ISSUE1: begin
          state_q    <= S_ISSUE2;
          addr_q     <= addr_q + 18'd1;
          word_cnt_q <= word_cnt_q + 17'd1;
        end
        S_ISSUE2, S_STALL: begin
          if (state_q == S_ISSUE2 && last_word) begin
            state_q <= S_DRAIN;
          end else if (credit_ok) begin
            state_q    <= S_ISSUE0;
            addr_q     <= addr_q + 18'd1;
            word_cnt_q <= word_cnt_q + 17'd1;
          end else begin
            state_q <= S_STALL;
          end
        end
        S_DRAIN: if (in_flight_q == '0 && fifo_empty) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-stage tag pipe lines up each issued word with its data two cycles later.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_phase_q <= PH_W0;
      s2_phase_q <= PH_W0;
      r0_q       <= '0;
      g0_q       <= '0;
      r1_q       <= '0;
    end else begin
      s1_valid_q <= issue_valid;
      s1_phase_q <= issue_phase;
      s2_valid_q <= s1_valid_q;
      s2_phase_q <= s1_phase_q;
      if (s2_valid_q && s2_phase_q == PH_W0) begin
        r0_q <= SRAM_read_data[15:8];
        g0_q <= SRAM_read_data[7:0];
      end
      if (s2_valid_q && s2_phase_q == PH_W1) begin
        r1_q <= SRAM_read_data[7:0];
      end
    end
  end

  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    if (s2_valid_q) begin
      case (s2_phase_q)
        PH_W1: begin
          fifo_push  = 1'b1;
          fifo_wdata = '{r: r0_q, g: g0_q, b: SRAM_read_data[15:8]};
        end
        PH_W2: begin
          fifo_push  = 1'b1;
          fifo_wdata = '{r: r1_q, g: SRAM_read_data[15:8], b: SRAM_read_data[7:0]};
        end
        default: ;
      endcase
    end
  end

  assign fifo_pop = !fifo_empty && Pixel_ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Resetn),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_push_when_full: assert property (@(posedge Clock) disable iff (!Resetn)
    !(fifo_push && fifo_full));

  assign SRAM_address    = addr_q;
  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = 16'd0;
  assign Pixel_R         = fifo_rdata.r;
  assign Pixel_G         = fifo_rdata.g;
  assign Pixel_B         = fifo_rdata.b;
  assign Pixel_valid     = !fifo_empty;
  assign Busy            = busy_q;
  assign Frame_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb_frame_reader.sv
// Directed bench for rgb_frame_reader: a 16-pixel frame against a 2-cycle SRAM model
// whose word at address a is a[15:0].
`timescale 1ns/1ps
`default_nettype none

module tb_rgb_frame_reader;

  localparam logic [17:0] BASE  = 18'd146944;
  localparam int          NPIX  = 16;
  localparam int          DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic        Pixel_ready = 1'b0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data = 16'd0;
  logic        SRAM_we_n;
  logic [15:0] SRAM_write_data;
  logic [7:0]  Pixel_R, Pixel_G, Pixel_B;
  logic        Pixel_valid;
  logic        Busy;
  logic        Frame_done;

  rgb_frame_reader #(
    .RGB_BASE   (BASE),
    .NUM_PIXELS (NPIX),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .Enable          (Enable),
    .SRAM_address    (SRAM_address),
    .SRAM_read_data  (SRAM_read_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_write_data (SRAM_write_data),
    .Pixel_R         (Pixel_R),
    .Pixel_G         (Pixel_G),
    .Pixel_B         (Pixel_B),
    .Pixel_valid     (Pixel_valid),
    .Pixel_ready     (Pixel_ready),
    .Busy            (Busy),
    .Frame_done      (Frame_done)
  );

  always #5 Clock = ~Clock;

  logic [15:0] sram_d1 = 16'd0;
  always @(posedge Clock) begin
    sram_d1        <= SRAM_address[15:0];
    SRAM_read_data <= sram_d1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [23:0] exp_pix(input int n);
    logic [17:0] a;
    logic [15:0] w0, w1, w2;
    a  = BASE + 18'(3 * (n / 2));
    w0 = a[15:0];
    w1 = w0 + 16'd1;
    w2 = w0 + 16'd2;
    if (n % 2 == 0) return {w0, w1[15:8]};
    else            return {w1[7:0], w2};
  endfunction

  int          pix_idx = 0, accepted = 0, done_count = 0, addr_changes = 0;
  int          first_acc_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  logic [17:0] last_addr = 18'd0;

  always @(negedge Clock) begin
    if (Resetn) begin
      if (Pixel_valid && Pixel_ready) begin
        checks++;
        assert ({Pixel_R, Pixel_G, Pixel_B} === exp_pix(pix_idx)) else begin
          errors++;
          $error("FAIL pixel[%0d]: observed %h expected %h", pix_idx,
                 {Pixel_R, Pixel_G, Pixel_B}, exp_pix(pix_idx));
        end
        if (accepted == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        accepted++;
        pix_idx++;
      end
      if (Frame_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (SRAM_address !== last_addr) begin
        addr_changes++;
        last_addr = SRAM_address;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_mon();
    pix_idx = 0; accepted = 0; done_count = 0; addr_changes = 0;
    first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_frame();
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clock);
      seen = Frame_done;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(SRAM_address), 32'd0);
    chk({tag, "_we_n"},  32'(SRAM_we_n), 32'd1);
    chk({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
    chk({tag, "_valid"}, 32'(Pixel_valid), 32'd0);
    chk({tag, "_rgb"},   32'({Pixel_R, Pixel_G, Pixel_B}), 32'd0);
    chk({tag, "_busy"},  32'(Busy), 32'd0);
    chk({tag, "_done"},  32'(Frame_done), 32'd0);
  endtask

  logic [23:0] held_pix;

  initial begin
    // Reset state
    #3;
    chk_reset_outputs("rst");
    repeat (2) tick();
    Resetn = 1'b1;
    tick();

    // Frame with consumer always ready: latency, pixel order, throughput, done timing
    clear_mon();
    Pixel_ready = 1'b1;
    start_frame();
    chk("a_busy", 32'(Busy), 32'd1);
    chk("a_first_addr", 32'(SRAM_address), 32'(BASE));
    chk("a_valid_t1", 32'(Pixel_valid), 32'd0);
    repeat (3) tick();
    chk("a_valid_t3", 32'(Pixel_valid), 32'd0);
    tick();
    chk("a_valid_t4", 32'(Pixel_valid), 32'd1);
    chk("a_pix0_head", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(exp_pix(0)));
    wait_done("a", 200);
    chk("a_busy_in_done", 32'(Busy), 32'd1);
    tick();
    chk("a_busy_idle", 32'(Busy), 32'd0);
    chk("a_pixels", 32'(accepted), 32'(NPIX));
    chk("a_done_count", 32'(done_count), 32'd1);
    chk("a_reads", 32'(addr_changes), 32'(NPIX * 3 / 2));
    chk("a_last_addr", 32'(last_addr), 32'(BASE + 18'(NPIX * 3 / 2 - 1)));
    chk("a_throughput", 32'(last_acc_cyc - first_acc_cyc), 32'd22);
    chk("a_done_lag", 32'(done_cyc - last_acc_cyc), 32'd2);

    // Consumer stalled: FIFO fills to 8, reads freeze, head holds; then toggled ready
    clear_mon();
    Pixel_ready = 1'b0;
    start_frame();
    repeat (50) tick();
    chk("b_stall_addr", 32'(SRAM_address), 32'(BASE + 18'd11));
    chk("b_fifo_count", 32'(dut.u_fifo.count_o), 32'(DEPTH));
    chk("b_valid", 32'(Pixel_valid), 32'd1);
    chk("b_none_taken", 32'(accepted), 32'd0);
    held_pix = {Pixel_R, Pixel_G, Pixel_B};
    chk("b_head", 32'(held_pix), 32'(exp_pix(0)));
    repeat (5) tick();
    chk("b_head_hold", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(held_pix));
    chk("b_addr_hold", 32'(SRAM_address), 32'(BASE + 18'd11));
    for (int i = 0; i < 400 && done_count == 0; i++) begin
      Pixel_ready = (i % 2 == 0);
      tick();
    end
    Pixel_ready = 1'b0;
    tick();
    chk("b_done_count", 32'(done_count), 32'd1);
    chk("b_pixels", 32'(accepted), 32'(NPIX));
    chk("b_reads", 32'(addr_changes), 32'(NPIX * 3 / 2));
    chk("b_last_addr", 32'(last_addr), 32'(BASE + 18'(NPIX * 3 / 2 - 1)));

    // Reset mid-frame, then a clean restart from the base address
    clear_mon();
    Pixel_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 100 && accepted < 5; i++) tick();
    chk("c_mid_reached", 32'(accepted >= 5), 32'd1);
    @(negedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    chk_reset_outputs("c_rst");
    tick();
    Resetn = 1'b1;
    clear_mon();
    tick();
    start_frame();
    chk("c_restart_addr", 32'(SRAM_address), 32'(BASE));
    wait_done("c", 200);
    tick();
    chk("c_pixels", 32'(accepted), 32'(NPIX));
    chk("c_done_count", 32'(done_count), 32'd1);

    // Enable held high: one frame per IDLE visit
    clear_mon();
    Enable = 1'b1;
    tick();
    chk("d_busy", 32'(Busy), 32'd1);
    wait_done("d", 200);
    chk("d_busy_in_done", 32'(Busy), 32'd1);
    tick();
    chk("d_busy_idle", 32'(Busy), 32'd0);
    chk("d_pixels", 32'(accepted), 32'(NPIX));
    chk("d_done_count", 32'(done_count), 32'd1);
    tick();
    Enable = 1'b0;
    clear_mon();
    chk("d_rearm_busy", 32'(Busy), 32'd1);
    chk("d_rearm_addr", 32'(SRAM_address), 32'(BASE));
    wait_done("d2", 200);
    tick();
    chk("d2_pixels", 32'(accepted), 32'(NPIX));
    chk("d2_done_count", 32'(done_count), 32'd1);
    chk("d2_busy", 32'(Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
